ptw_arbiter: RTL and testbench
==============================

# ptw_arbiter

Translation controller that shares one page-table walker between the instruction-fetch requester (I) and the data-access requester (D). It arbitrates round-robin, short-circuits Bare mode and repeat translations through a one-entry last-translation cache per requester, sequences the walker's start/done handshake, and returns a physical address or a fault to the granted requester. It sits between the fetch/memory stages and the walker.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- satp  in  64  current satp; mode = satp[63:60] (0 Bare, 8 Sv39, 9 Sv48)
- flush  in  1  one-cycle pulse (sfence.vma); invalidates both cache entries
- i_req / d_req  in  1  translation request; held with its VA stable until the matching ready
- i_va / d_va  in  64  virtual address
- i_ready / d_ready  out  1  one-cycle response pulse
- i_pa / d_pa  out  64  physical address; valid while ready
- i_fault / d_fault  out  1  page fault; valid while ready; pa = 0 when set
- walk_en  out  1  walker start strobe
- walk_va  out  64  VA presented to the walker; held from START through WAIT
- walk_done  in  1  walker completion; qualifies walk_valid and walk_pa
- walk_valid  in  1  translation succeeded
- walk_pa  in  64  translated PA

## Operation
- State register: IDLE, START, WAIT, RESP. Also: `gnt` (0 = I, 1 = D), `last` (most recent grant), `sel_va`, `res_pa`, `res_fault`, `satp_q`.
- Cache entries, one per requester: `v`, tag = va[63:12], ppn = pa[63:12].
  - Hit: v && tag == va[63:12].
  - Hit result: {ppn, va[11:0]}.
- IDLE
  - No request: stay in IDLE.
  - Arbitration:
    - One requester: grant it.
    - Both requesting: grant the requester that is not `last`.
  - On grant: set `gnt`, set `last` = gnt, latch `sel_va`.
  - Bare mode (mode == 0): res_pa = va, res_fault = 0, go to RESP.
  - Cache hit: res_pa = hit result, res_fault = 0, go to RESP.
  - Otherwise go to START.
  - Mode not in {0, 8, 9}: res_fault = 1, res_pa = 0, go to RESP. No walk is started.
- START
  - walk_en = 1 for exactly one cycle.
  - Next state is WAIT.
- WAIT
  - walk_en = 0; stay until walk_done.
  - walk_done is ignored outside WAIT; the walker may assert it while idle.
  - On walk_done:
    - res_pa = walk_valid ? walk_pa : 0.
    - res_fault = ~walk_valid.
    - Fill the granted requester's cache entry only when walk_valid and no invalidation occurred since START.
    - Next state is RESP.
- RESP
  - Assert the granted requester's ready, pa and fault.
  - The other requester's ready stays 0.
  - Next state is IDLE.
- walk_va = sel_va in START and WAIT, 0 otherwise.
- Invalidation
  - Triggers: flush = 1, or satp != satp_q (satp_q updates every cycle).
  - Effect: clears both v bits in the same cycle.
  - A walk in flight still completes and responds, but its result is not cached.
- A request held high in the cycle after its ready is treated as a new request.

## Timing
- Reset values: state IDLE, last = D (I wins the first tie), both v = 0. All outputs 0: ready, pa, fault, walk_en, walk_va.
- Bare mode or cache hit:
  - Request seen in IDLE in cycle N; ready in cycle N+1.
  - Back in IDLE at N+2; minimum request-to-request spacing is 2 cycles.
- Miss:
  - IDLE at N, START (walk_en) at N+1, WAIT from N+2.
  - walk_done in cycle M leads to ready in cycle M+1.
  - Minimum latency is 4 cycles when walk_done arrives at N+2.
- Outputs are state/register decoded. No combinational path exists from i_req, d_req, i_va, d_va or walk_* to any output.
- Only one translation is in flight. The non-granted requester waits in IDLE arbitration, and round-robin bounds its wait to one translation.
- Simultaneous flush and fill in the WAIT/done cycle: invalidation wins and the entry stays invalid.
- Reset mid-walk: return to IDLE immediately and drop the response. The walker is reset by the same signal.

## Test plan
- Bare mode: satp = 0, i_req with i_va = 0x8000_1234 → i_ready at N+1 with i_pa = 0x8000_1234 and i_fault = 0; walk_en never asserted.
- Sv39 miss then hit: satp = 0x8000_0000_0008_0000. d_va = 0x4000_0ABC; walker answers walk_pa = 0x8765_4ABC after 3 WAIT cycles.
  - First request: walk_en one pulse; d_ready one cycle after walk_done with d_pa = 0x8765_4ABC.
  - Repeat with d_va = 0x4000_0FFF: d_ready at N+1 with d_pa = 0x8765_4FFF, no walk.
- Tie arbitration: i_req and d_req both asserted from reset and held.
  - Grant order is I, D, I, D.
  - Each response pulses only its own ready.
- Fault: walk_done with walk_valid = 0 → d_fault = 1 and d_pa = 0.
  - The same VA re-requested walks again (fault not cached).
- Invalidation: after an I cache fill, pulse flush (or change satp[43:0]) → the next i_req to the same page walks.
  - Flush asserted during WAIT: response still delivered, not cached.
- Reset in WAIT → all outputs 0 next cycle, state IDLE, no ready pulse for the aborted request.

Source files
------------

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: shares one page-table walker between the fetch (I) and data (D)
// requesters. Grants are round-robin. Bare mode and repeat pages are answered
// from a one-entry cache per requester; everything else goes through the
// walker's start/done handshake.
//
// state | meaning
// IDLE  | arbitrate; answer Bare/hit/bad-mode directly, else start a walk
// START | one-cycle walk_en strobe toward the walker
// WAIT  | walker busy; capture its result on walk_done
// RESP  | one-cycle ready pulse to the granted requester
module ptw_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] satp,
   input  logic        flush,
   input  logic        i_req,
   input  logic [63:0] i_va,
   input  logic        d_req,
   input  logic [63:0] d_va,
   output logic        i_ready,
   output logic [63:0] i_pa,
   output logic        i_fault,
   output logic        d_ready,
   output logic [63:0] d_pa,
   output logic        d_fault,
   output logic        walk_en,
   output logic [63:0] walk_va,
   input  logic        walk_done,
   input  logic        walk_valid,
   input  logic [63:0] walk_pa
);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t           state;
   state_t           state_nxt;

   logic             gnt;
   logic             last;
   logic [63:0]      sel_va;
   logic [63:0]      res_pa;
   logic             res_fault;
   logic [63:0]      satp_q;
   logic             inval_seen;

   logic [1:0]       c_v;
   logic [1:0][51:0] c_tag;
   logic [1:0][51:0] c_ppn;

   logic             any_req;
   logic             arb_gnt;
   logic [63:0]      arb_va;
   logic [3:0]       mode;
   logic             mode_bare;
   logic             mode_ok;
   logic             inval;
   logic             arb_hit;
   logic [63:0]      hit_pa;

   // Arbitration, mode decode, invalidation and cache lookup for the candidate grant
   always_comb begin
      any_req   = i_req | d_req;
      arb_gnt   = (i_req & d_req) ? ~last : d_req;
      arb_va    = arb_gnt ? d_va : i_va;
      mode      = satp[63:60];
      mode_bare = (mode == 4'd0);
      mode_ok   = (mode == 4'd8) || (mode == 4'd9);
      inval     = flush | (satp != satp_q);
      // an invalidation in the lookup cycle already counts as having cleared the entry
      arb_hit   = c_v[arb_gnt] & ~inval & (c_tag[arb_gnt] == arb_va[63:12]);
      hit_pa    = {c_ppn[arb_gnt], arb_va[11:0]};
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               if (mode_bare || !mode_ok || arb_hit) state_nxt = RESP;
               else                                  state_nxt = START;
            end
         end
         START:   state_nxt = WAIT;
         WAIT:    if (walk_done) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state and registered results only
   always_comb begin
      i_ready = (state == RESP) & ~gnt;
      d_ready = (state == RESP) &  gnt;
      i_pa    = i_ready ? res_pa : 64'd0;
      d_pa    = d_ready ? res_pa : 64'd0;
      i_fault = i_ready & res_fault;
      d_fault = d_ready & res_fault;
      walk_en = (state == START);
      walk_va = ((state == START) || (state == WAIT)) ? sel_va : 64'd0;
   end

   // Grant bookkeeping and response capture
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt        <= 1'b0;
         last       <= 1'b1;
         sel_va     <= 64'd0;
         res_pa     <= 64'd0;
         res_fault  <= 1'b0;
         satp_q     <= 64'd0;
         inval_seen <= 1'b0;
      end else begin
         satp_q <= satp;
         if (state == IDLE && any_req) begin
            gnt        <= arb_gnt;
            last       <= arb_gnt;
            sel_va     <= arb_va;
            inval_seen <= 1'b0;
            if (mode_bare) begin
               res_pa    <= arb_va;
               res_fault <= 1'b0;
            end else if (!mode_ok) begin
               res_pa    <= 64'd0;
               res_fault <= 1'b1;
            end else if (arb_hit) begin
               res_pa    <= hit_pa;
               res_fault <= 1'b0;
            end
         end
         // remember any invalidation while a walk is outstanding so its result is not cached
         if ((state == START || state == WAIT) && inval) inval_seen <= 1'b1;
         if (state == WAIT && walk_done) begin
            res_pa    <= walk_valid ? walk_pa : 64'd0;
            res_fault <= ~walk_valid;
         end
      end
   end

   // Last-translation cache; invalidation takes priority over a same-cycle fill
   always_ff @(posedge clk) begin
      if (reset) begin
         c_v   <= 2'b00;
         c_tag <= '0;
         c_ppn <= '0;
      end else if (inval) begin
         c_v <= 2'b00;
      end else if (state == WAIT && walk_done && walk_valid && !inval_seen) begin
         c_v[gnt]   <= 1'b1;
         c_tag[gnt] <= sel_va[63:12];
         c_ppn[gnt] <= walk_pa[63:12];
      end
   end

endmodule

// File: tb/tb_ptw_arbiter.sv
// Bench for ptw_arbiter: constant vector table, hand sequences for reset and
// arbitration corners, then randomized rounds against a transaction-level model.
module tb_ptw_arbiter;

   logic        clk;
   logic        reset;
   logic [63:0] satp;
   logic        flush;
   logic        i_req, d_req;
   logic [63:0] i_va, d_va;
   logic        i_ready, d_ready;
   logic [63:0] i_pa, d_pa;
   logic        i_fault, d_fault;
   logic        walk_en;
   logic [63:0] walk_va;
   logic        walk_done, walk_valid;
   logic [63:0] walk_pa;

   ptw_arbiter dut (
      .clk(clk), .reset(reset), .satp(satp), .flush(flush),
      .i_req(i_req), .i_va(i_va), .d_req(d_req), .d_va(d_va),
      .i_ready(i_ready), .i_pa(i_pa), .i_fault(i_fault),
      .d_ready(d_ready), .d_pa(d_pa), .d_fault(d_fault),
      .walk_en(walk_en), .walk_va(walk_va),
      .walk_done(walk_done), .walk_valid(walk_valid), .walk_pa(walk_pa)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] SV39 = 64'h8000_0000_0008_0000;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model state: round-robin pointer and one cache entry per requester
   bit          m_last;
   bit   [1:0]  mv;
   logic [51:0] mtag [2];
   logic [51:0] mppn [2];

   // walker behaviour: fixed answer for table vectors, address hash otherwise
   bit          ov_en;
   logic [63:0] ov_pa;
   bit          ov_valid;
   int          ov_delay;
   bit          ov_flush_done;
   bit          rnd_flush;

   logic [63:0] obs_pa;
   bit          obs_f;
   int          obs_w;

   typedef struct {
      logic [63:0] satp;
      bit          fp;
      bit          is_d;
      logic [63:0] va;
      bit          wv;
      logic [63:0] wpa;
      int          wd;
      bit          fm;
      logic [63:0] epa;
      bit          ef;
      int          ew;
   } vec_t;

   vec_t        tbl [14];
   logic [63:0] pool [6];
   logic [63:0] satps [5];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   function automatic void walker_fn(input logic [63:0] va, output logic [63:0] pa, output bit valid);
      if (ov_en) begin
         pa    = ov_pa;
         valid = ov_valid;
      end else begin
         pa    = {va[63:12] ^ 52'h00F0F12345678, va[11:0]};
         valid = !(va[12] && va[13]);
      end
   endfunction

   // expected outcome of one translation, evaluated when the request is granted
   function automatic void model_expect(input bit r, input logic [63:0] va,
                                        output logic [63:0] pa, output bit f, output bit w);
      logic [3:0]  mode;
      logic [63:0] wpa;
      bit          wv;
      mode = satp[63:60];
      w    = 1'b0;
      f    = 1'b0;
      if (mode == 4'd0) begin
         pa = va;
      end else if (mode != 4'd8 && mode != 4'd9) begin
         pa = 64'd0;
         f  = 1'b1;
      end else if (mv[r] && mtag[r] == va[63:12]) begin
         pa = {mppn[r], va[11:0]};
      end else begin
         walker_fn(va, wpa, wv);
         w  = 1'b1;
         pa = wv ? wpa : 64'd0;
         f  = !wv;
      end
   endfunction

   // idle cycles between rounds, optionally pulsing flush and/or changing satp
   task automatic gap(input bit fl, input logic [63:0] ns);
      tick();
      chk("idle_quiet", 64'({i_ready, d_ready, walk_en}), 64'd0);
      flush = fl;
      if (fl || ns != satp) mv = 2'b00;
      satp = ns;
      tick();
      flush = 1'b0;
      chk("idle_quiet", 64'({i_ready, d_ready, walk_en}), 64'd0);
   endtask

   task automatic run_round(input bit ie, input bit de, input logic [63:0] vi, input logic [63:0] vd);
      bit          ord [2];
      int          n, idx;
      bit          r;
      logic [63:0] cva, e_pa, wpa;
      bit          e_f, e_w, wv, wflushed, finished;
      int          exp_cyc, walks, done_cyc, cd;
      if (ie && de) begin
         ord[0] = !m_last; ord[1] = m_last; n = 2;
      end else begin
         ord[0] = de; ord[1] = 1'b0; n = 1;
      end
      i_req = ie; i_va = vi; d_req = de; d_va = vd;
      idx = 0;
      r   = ord[0];
      cva = r ? vd : vi;
      model_expect(r, cva, e_pa, e_f, e_w);
      m_last = r;
      exp_cyc = cyc + 1; walks = 0; done_cyc = -100; cd = -1; wflushed = 1'b0; finished = 1'b0;
      for (int t = 0; t < 80 && !finished; t++) begin
         tick();
         flush = 1'b0; walk_done = 1'b0; walk_valid = 1'b0; walk_pa = 64'd0;
         if (walk_en) begin
            walks++;
            if (walks == 1) begin
               chk("walk_en_cycle", 64'(cyc), 64'(exp_cyc));
               chk("walk_va", walk_va, cva);
            end
            cd = ov_en ? ov_delay : int'($urandom_range(0, 3));
         end else if (cd > 0) begin
            cd--;
         end else if (cd == 0) begin
            walker_fn(cva, wpa, wv);
            walk_done = 1'b1; walk_valid = wv; walk_pa = wpa;
            done_cyc = cyc; cd = -1;
            if (ov_en && ov_flush_done) flush = 1'b1;
         end
         if (rnd_flush && walks > 0 && (cd >= 0 || done_cyc == cyc) && $urandom_range(0, 5) == 0)
            flush = 1'b1;
         if (flush) begin
            wflushed = 1'b1;
            mv = 2'b00;
         end
         if (i_ready || d_ready) begin
            chk("ready_who", 64'({i_ready, d_ready}), r ? 64'd1 : 64'd2);
            chk("resp_pa", r ? d_pa : i_pa, e_pa);
            chk("resp_fault", 64'(r ? d_fault : i_fault), 64'(e_f));
            chk("walk_count", 64'(walks), 64'(e_w));
            chk("ready_cycle", 64'(cyc), e_w ? 64'(done_cyc + 1) : 64'(exp_cyc));
            if (e_w && !e_f && !wflushed) begin
               mv[r]   = 1'b1;
               mtag[r] = cva[63:12];
               mppn[r] = e_pa[63:12];
            end
            obs_pa = r ? d_pa : i_pa;
            obs_f  = r ? d_fault : i_fault;
            obs_w  = walks;
            if (r) d_req = 1'b0;
            else   i_req = 1'b0;
            idx++;
            if (idx == n) begin
               finished = 1'b1;
            end else begin
               r   = ord[idx];
               cva = r ? vd : vi;
               model_expect(r, cva, e_pa, e_f, e_w);
               m_last = r;
               exp_cyc = cyc + 2; walks = 0; done_cyc = -100; cd = -1; wflushed = 1'b0;
            end
         end
      end
      if (!finished) begin
         n_vec++;
         n_err++;
         $display("FAIL round_timeout: got no response, required %0d responses (cycle %0d)", n - idx, cyc);
         i_req = 1'b0; d_req = 1'b0;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_who;
      bit          found;
      reset = 1'b1; satp = 64'd0; flush = 1'b0;
      i_req = 1'b0; d_req = 1'b0; i_va = 64'd0; d_va = 64'd0;
      walk_done = 1'b0; walk_valid = 1'b0; walk_pa = 64'd0;
      ov_en = 1'b0; ov_pa = 64'd0; ov_valid = 1'b0; ov_delay = 0; ov_flush_done = 1'b0; rnd_flush = 1'b0;
      m_last = 1'b1; mv = 2'b00;
      mtag[0] = '0; mtag[1] = '0; mppn[0] = '0; mppn[1] = '0;
      obs_pa = 64'd0; obs_f = 1'b0; obs_w = 0;
      pool[0] = 64'h0000_0000_4000_0000; pool[1] = 64'h0000_0000_4000_1000;
      pool[2] = 64'h0000_0000_4000_3000; pool[3] = 64'h0000_0000_7FFF_F000;
      pool[4] = 64'hFFFF_FFC0_0000_2000; pool[5] = 64'h0000_0000_0000_1000;
      satps[0] = SV39;                   satps[1] = 64'h9000_0000_0008_0000;
      satps[2] = 64'h0;                  satps[3] = 64'hA000_0000_0000_0000;
      satps[4] = 64'h8000_0000_0008_0123;

      //        satp                    fp    is_d  va                      wv    wpa                     wd  fm    epa                     ef    ew
      tbl[0]  = '{64'h0,                 1'b0, 1'b0, 64'h0000_0000_8000_1234, 1'b1, 64'h0,                  0, 1'b0, 64'h0000_0000_8000_1234, 1'b0, 0};
      tbl[1]  = '{SV39,                  1'b0, 1'b1, 64'h0000_0000_4000_0ABC, 1'b1, 64'h0000_0000_8765_4ABC, 2, 1'b0, 64'h0000_0000_8765_4ABC, 1'b0, 1};
      tbl[2]  = '{SV39,                  1'b0, 1'b1, 64'h0000_0000_4000_0FFF, 1'b1, 64'h0,                  0, 1'b0, 64'h0000_0000_8765_4FFF, 1'b0, 0};
      tbl[3]  = '{SV39,                  1'b0, 1'b1, 64'h0000_0000_5000_0000, 1'b0, 64'h0000_0000_DEAD_0000, 0, 1'b0, 64'h0,                  1'b1, 1};
      tbl[4]  = '{SV39,                  1'b0, 1'b1, 64'h0000_0000_5000_0000, 1'b0, 64'h0000_0000_DEAD_0000, 1, 1'b0, 64'h0,                  1'b1, 1};
      tbl[5]  = '{SV39,                  1'b0, 1'b0, 64'h0000_0000_4000_0123, 1'b1, 64'h0000_0001_2345_6123, 1, 1'b0, 64'h0000_0001_2345_6123, 1'b0, 1};
      tbl[6]  = '{SV39,                  1'b0, 1'b0, 64'h0000_0000_4000_0456, 1'b1, 64'h0,                  0, 1'b0, 64'h0000_0001_2345_6456, 1'b0, 0};
      tbl[7]  = '{SV39,                  1'b1, 1'b0, 64'h0000_0000_4000_0456, 1'b1, 64'h0000_0001_2345_6456, 0, 1'b1, 64'h0000_0001_2345_6456, 1'b0, 1};
      tbl[8]  = '{SV39,                  1'b0, 1'b0, 64'h0000_0000_4000_0789, 1'b1, 64'h0000_0001_2345_6789, 3, 1'b0, 64'h0000_0001_2345_6789, 1'b0, 1};
      tbl[9]  = '{SV39,                  1'b0, 1'b0, 64'h0000_0000_4000_0789, 1'b1, 64'h0,                  0, 1'b0, 64'h0000_0001_2345_6789, 1'b0, 0};
      tbl[10] = '{64'h8000_0000_0008_0001, 1'b0, 1'b0, 64'h0000_0000_4000_0789, 1'b1, 64'h0000_0001_2345_6789, 0, 1'b0, 64'h0000_0001_2345_6789, 1'b0, 1};
      tbl[11] = '{64'h5000_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_4000_0789, 1'b1, 64'h0,                  0, 1'b0, 64'h0,                  1'b1, 0};
      tbl[12] = '{64'h9000_0000_0008_0001, 1'b0, 1'b1, 64'h0000_0000_4000_0FFF, 1'b1, 64'h0000_0000_8765_4FFF, 1, 1'b0, 64'h0000_0000_8765_4FFF, 1'b0, 1};
      tbl[13] = '{64'h9000_0000_0008_0001, 1'b0, 1'b1, 64'h0000_0000_4000_0001, 1'b1, 64'h0,                  0, 1'b0, 64'h0000_0000_8765_4001, 1'b0, 0};

      // reset state, then a held tie from reset in Bare mode: I, D, I, D
      i_req = 1'b1; d_req = 1'b1;
      i_va = 64'h0000_0000_0000_1111; d_va = 64'h0000_0000_0000_2222;
      tick(); tick();
      chk("reset_flags", 64'({i_ready, d_ready, i_fault, d_fault, walk_en}), 64'd0);
      chk("reset_i_pa", i_pa, 64'd0);
      chk("reset_d_pa", d_pa, 64'd0);
      chk("reset_walk_va", walk_va, 64'd0);
      reset = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         exp_who = (t % 4 == 1) ? 64'd2 : (t % 4 == 3) ? 64'd1 : 64'd0;
         chk("tie_ready", 64'({i_ready, d_ready}), exp_who);
         if (i_ready) chk("tie_i_pa", i_pa, i_va);
         if (d_ready) chk("tie_d_pa", d_pa, d_va);
      end
      i_req = 1'b0; d_req = 1'b0;
      m_last = 1'b1;

      // fixed vectors: Bare, miss/hit, fault not cached, flush/satp invalidation, bad mode
      ov_en = 1'b1;
      for (int k = 0; k < 14; k++) begin
         ov_pa = tbl[k].wpa; ov_valid = tbl[k].wv; ov_delay = tbl[k].wd; ov_flush_done = tbl[k].fm;
         gap(tbl[k].fp, tbl[k].satp);
         run_round(!tbl[k].is_d, tbl[k].is_d, tbl[k].va, tbl[k].va);
         chk("tbl_pa", obs_pa, tbl[k].epa);
         chk("tbl_fault", 64'(obs_f), 64'(tbl[k].ef));
         chk("tbl_walks", 64'(obs_w), 64'(tbl[k].ew));
      end
      ov_en = 1'b0; ov_flush_done = 1'b0;

      // reset while the walker is busy: outputs drop next cycle, no response, idle walk_done ignored
      gap(1'b0, SV39);
      d_req = 1'b1; d_va = 64'h0000_0000_6000_0040;
      found = 1'b0;
      for (int t = 0; t < 6 && !found; t++) begin
         tick();
         if (walk_en) found = 1'b1;
      end
      chk("rst_walk_started", 64'(found), 64'd1);
      tick();
      reset = 1'b1; d_req = 1'b0;
      tick();
      chk("rst_flags", 64'({i_ready, d_ready, i_fault, d_fault, walk_en}), 64'd0);
      chk("rst_pa", i_pa | d_pa, 64'd0);
      chk("rst_walk_va", walk_va, 64'd0);
      reset = 1'b0; walk_done = 1'b1; walk_valid = 1'b1; walk_pa = 64'h0000_0000_1234_5040;
      m_last = 1'b1; mv = 2'b00;
      for (int t = 0; t < 3; t++) begin
         tick();
         walk_done = 1'b0; walk_valid = 1'b0; walk_pa = 64'd0;
         chk("rst_no_ready", 64'({i_ready, d_ready, walk_en}), 64'd0);
      end
      gap(1'b0, SV39);
      run_round(1'b0, 1'b1, 64'd0, 64'h0000_0000_6000_0040);

      // randomized rounds against the model
      rnd_flush = 1'b1;
      for (int k = 0; k < 400; k++) begin
         logic [63:0] ns, vi, vd;
         int          sel;
         ns  = ($urandom_range(0, 7) == 0) ? satps[$urandom_range(0, 4)] : satp;
         gap($urandom_range(0, 9) == 0, ns);
         sel = int'($urandom_range(1, 3));
         vi  = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 4095));
         vd  = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 4095));
         run_round(sel[0], sel[1], vi, vd);
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
